// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode constants: predecode opcodes, the canonical NOP,
// and the flag bundle produced by if_predecode.
package if_id_queue_pkg;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic is_jal;
    logic is_jalr;
    logic is_branch;
  } predec_t;
endpackage

// File: rtl/if_id_queue_predecode.sv
// Combinational control-flow predecode from the major opcode field.
// Decode can instantiate this too, so it only ever sees inst[6:0].
module if_predecode
  import if_id_queue_pkg::*;
(
  input  logic [6:0] opcode_i,
  output predec_t    flags_o
);
  always_comb begin
    flags_o           = '0;
    flags_o.is_jal    = (opcode_i == OPC_JAL);
    flags_o.is_jalr   = (opcode_i == OPC_JALR);
    flags_o.is_branch = (opcode_i == OPC_BRANCH);
  end
endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: circular buffer with wrap-bit pointers,
// valid/ready on both sides, flush on redirect, predecoded head flags.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_is_branch,
  output logic [PW-1:0]   count
);
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [ILEN-1:0] inst_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  logic            empty, full, push, pop;
  predec_t         flags;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

  // in_ready must not depend on out_ready: a full queue refuses even if decode pops.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready && !flush;

  always_comb begin
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset purely so waveforms start clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wr_q[AW-1:0]]   <= in_pc;
      inst_q[wr_q[AW-1:0]] <= in_inst;
    end
  end

  assign out_valid = !empty;
  assign out_pc    = empty ? '0 : pc_q[rd_q[AW-1:0]];
  assign out_inst  = empty ? ILEN'(INST_NOP) : inst_q[rd_q[AW-1:0]];
  assign count     = count_q;

  if_predecode u_predecode (
    .opcode_i (out_inst[6:0]),
    .flags_o  (flags)
  );

  assign out_is_jal    = flags.is_jal;
  assign out_is_jalr   = flags.is_jalr;
  assign out_is_branch = flags.is_branch;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= PW'(DEPTH));

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (!rst && push) $display("ifq push %x", in_pc);
  end
`endif
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the fetch stage and the decode stage of the 5-stage RV64 pipeline.
- Accepts fetched (pc, inst) pairs with a valid/ready handshake and holds up to DEPTH entries.
- Presents the oldest entry to decode with predecode flags for jal, jalr and branch.
- Replaces the fetch-side negedge hold-on-bubble latch: backpressure is by ready; redirects discard contents by flush.

Parameters:
- DEPTH, 2: number of queue entries; power of two, at least 2.
- XLEN, 64: pc width.
- ILEN, 32: instruction width.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: pipeline redirect (jal, taken branch, jalr, pc_panic trap); empties the queue.
- in_valid, input, 1: fetch presents an entry.
- in_ready, output, 1: queue can accept an entry this cycle.
- in_pc, input, XLEN: pc of the fetched instruction.
- in_inst, input, ILEN: fetched instruction.
- out_valid, output, 1: head entry is valid.
- out_ready, input, 1: decode consumes the head this cycle. Low means decode bubble or stall.
- out_pc, output, XLEN: head pc.
- out_inst, output, ILEN: head instruction.
- out_is_jal, output, 1: head opcode is 7'b1101111.
- out_is_jalr, output, 1: head opcode is 7'b1100111.
- out_is_branch, output, 1: head opcode is 7'b1100011.
- count, output, clog2(DEPTH)+1: current occupancy.

Behaviour:
- Storage is a circular buffer of DEPTH (pc, inst) registers.
  - wr_ptr and rd_ptr are clog2(DEPTH)+1 bits, including a wrap bit.
  - full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH naturally.
- in_ready = !full && !flush. It is combinational from state and flush only, never from out_ready.
- push = in_valid && in_ready. pop = out_valid && out_ready && !flush.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no empty-queue bypass.
- Output values:
  - out_valid = !empty.
  - When valid, out_pc, out_inst and the predecode flags come from the head register.
  - When empty: out_pc = 0, out_inst = 32'h00000013 (NOP), all predecode flags = 0.
- Predecode is combinational on the head instruction, decoding bits [6:0] only.
- Simultaneous push and pop:
  - Not full: both happen in the same cycle and count is unchanged.
  - Full: in_ready is 0, so only the pop happens. Fetch retries next cycle.
- Flush:
  - Highest priority after rst.
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0, out_valid = 0.
  - Any in_valid in the flush cycle is dropped, because in_ready = 0.
  - The pop is suppressed; decode must ignore the head in the flush cycle.
- Reset: pointers = 0, count = 0, out_valid = 0, and outputs take their empty values. Storage contents are don't-care.
- Reset mid-operation behaves exactly like flush, and additionally clears storage registers to 0 to aid waveform debug.
- count is updated registered:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH; an assertion in simulation checks this.
- Display: a $display("ifq push %x", in_pc) is emitted on push, gated by a DEBUG define.

Decomposition:
- Shared package holds the opcode constants OPC_JAL, OPC_JALR and OPC_BRANCH, and INST_NOP = 32'h00000013.
- The fetch and decode stages reuse these constants.
- One sub-module is natural: if_predecode, a combinational inst-to-flags decoder that the decode stage can also instantiate.

Test Plan:
- Reset, then idle:
  - Required: out_valid=0, out_inst=32'h00000013, out_pc=0, count=0, in_ready=1.
- Push pc=0x80000000 / inst=0x00000513, and pc=0x80000004 / inst=0x0000006f, with out_ready=0:
  - After cycle 2: count=2, in_ready=0, out_pc=0x80000000, out_is_jal=0.
  - Third push is refused.
- Queue full; out_ready=1 and in_valid=1 for one cycle:
  - Only the pop occurs; count=1, head pc=0x80000004, out_is_jal=1.
  - Next cycle, the retried push is accepted.
- Streaming with one entry held and in_valid=out_ready=1 for 8 cycles, pcs increasing by 4:
  - count stays 1; out_pc increments by 4 every cycle, 1 cycle behind in_pc.
  - No entry is lost or duplicated.
- Queue holding 2 entries; flush=1 together with in_valid=1 (pc=0x80000100):
  - Next cycle: count=0, out_valid=0.
  - Following push of 0x80000200 appears as head 1 cycle later, with no trace of 0x80000100.
- Wrap-around: 2*DEPTH+1 alternating push/pop pairs with inst opcodes cycling jal, jalr, branch:
  - Flags match the opcode of each head.
  - Pointers wrap without changing count.
